alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_mc.sv | 114 +++++++++++
 tb/tb_alu_mc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM encodings, plus NZCV bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_MUL = 3'b101,
    OP_RS6 = 3'b110,
    OP_RS7 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_reserved(input op_t o);
    return (o == OP_RS6) || (o == OP_RS7);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/logic datapath with NZCV generation.
// For OP_MUL the finished product arrives on a and C/V pass through from cv_in.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic [1:0]       cv_in,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             c, v;

  always_comb begin
    bx  = (op == OP_SUB) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        y = sum[WIDTH-1:0];
        c = sum[WIDTH];
        // overflow: like-signed operands producing an opposite-signed sum
        v = (a[WIDTH-1] == bx[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: y = a & b;
      OP_ORR: y = a | b;
      OP_EOR: y = a ^ b;
      OP_MUL: begin
        y = a;
        c = cv_in[1];
        v = cv_in[0];
      end
      default: y = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[WIDTH-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, WIDTH-cycle shift-add multiply,
// registered result held until consumed, and an architectural NZCV register.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       res_flags,
  output logic [3:0]       alu_flags
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, nxt;
  op_t              op_in, core_op;
  logic [WIDTH-1:0] ma, mb, acc, acc_next;
  logic [WIDTH-1:0] core_a, core_y;
  logic [3:0]       core_f;
  logic [CNT_W-1:0] cnt;
  logic             we_q, accept, mul_last;

  assign op_in    = op_t'(op);
  assign accept   = in_valid && in_ready;
  assign mul_last = (state == MUL) && (cnt == CNT_LAST);
  assign acc_next = acc + (mb[0] ? ma : '0);

  // On the last multiply step the core only forms N/Z and forwards C/V.
  assign core_a  = (state == MUL) ? acc_next : a;
  assign core_op = (state == MUL) ? OP_MUL : op_in;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (core_a),
    .b     (b),
    .op    (core_op),
    .cv_in (alu_flags[FLAG_C:FLAG_V]),
    .y     (core_y),
    .flags (core_f)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = (op_in == OP_MUL) ? MUL : DONE;
      end
      MUL:  if (cnt == CNT_LAST) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      res_flags <= '0;
      alu_flags <= '0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (op_in == OP_MUL) begin
          ma   <= a;
          mb   <= b;
          acc  <= '0;
          cnt  <= '0;
          we_q <= flag_we;
        end else begin
          result    <= core_y;
          res_flags <= core_f;
          if (flag_we && !op_reserved(op_in)) alu_flags <= core_f;
        end
      end
      if (state == MUL) begin
        acc <= acc_next;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt + CNT_W'(1);
        if (mul_last) begin
          cnt       <= '0;
          result    <= core_y;
          res_flags <= core_f;
          if (we_q) alu_flags <= core_f;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 (scoreboarded behavioural model) and WIDTH=8.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flag_we, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  op;
  logic [3:0]  res_flags, alu_flags;

  logic        in_valid8, in_ready8, flag_we8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  op8;
  logic [3:0]  res_flags8, alu_flags8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rf;
    logic [3:0]  af;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb8[$];
  logic [3:0]  model_af;
  logic [31:0] last_res;
  logic [3:0]  last_rf;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .flag_we(flag_we), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .res_flags(res_flags),
    .alu_flags(alu_flags)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .flag_we(flag_we8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .res_flags(res_flags8),
    .alu_flags(alu_flags8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [2:0] mop, input logic mwe,
                                 input logic [3:0] af);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] y;
    logic        c, v;
    y = 32'h0; c = 1'b0; v = 1'b0;
    case (mop)
      3'd0: begin
        s = {1'b0, ma} + {1'b0, mb};
        y = s[31:0]; c = s[32];
        v = (ma[31] == mb[31]) && (y[31] != ma[31]);
      end
      3'd1: begin
        s = {1'b0, ma} - {1'b0, mb};
        y = s[31:0]; c = (ma >= mb);
        v = (ma[31] != mb[31]) && (y[31] != ma[31]);
      end
      3'd2: y = ma & mb;
      3'd3: y = ma | mb;
      3'd4: y = ma ^ mb;
      3'd5: begin
        p = {32'h0, ma} * {32'h0, mb};
        y = p[31:0]; c = af[1]; v = af[0];
      end
      default: y = 32'h0;
    endcase
    e.res = y;
    e.rf  = {y[31], (y == 32'h0), c, v};
    e.af  = (mwe && mop < 3'd6) ? e.rf : af;
    e.lat = (mop == 3'd5) ? 33 : 1;
    return e;
  endfunction

  // Drive one request, then scramble the inputs to show they are not re-sampled.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb2,
                       input logic [2:0] top, input logic twe, input string tag);
    exp_t e;
    @(negedge clk);
    chk({tag, " in_ready"}, in_ready, 1);
    a = ta; b = tb2; op = top; flag_we = twe; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb2 ^ 32'h55; op = top ^ 3'b010; flag_we = ~twe;
    e = model(ta, tb2, top, twe, model_af);
    model_af = e.af;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (out_valid !== 1'b1 && lat < 200);
    chk({tag, " scoreboard"}, (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " result"}, result, e.res);
    chk({tag, " res_flags"}, res_flags, e.rf);
    chk({tag, " alu_flags"}, alu_flags, e.af);
    last_res = result; last_rf = res_flags;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 32'h1; b = 32'h1; op = 3'd0; flag_we = 1'b1;
      @(negedge clk);
      chk({tag, " hold valid"}, out_valid, 1);
      chk({tag, " hold in_ready"}, in_ready, 0);
      chk({tag, " hold result"}, result, e.res);
      chk({tag, " hold alu_flags"}, alu_flags, e.af);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " released"}, out_valid, 0);
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb2, input logic [2:0] top,
                      input logic [7:0] eres, input logic [3:0] erf, input logic [3:0] eaf,
                      input int elat, input string tag);
    exp_t e;
    int   lat;
    e.res = {24'h0, eres}; e.rf = erf; e.af = eaf; e.lat = elat;
    @(negedge clk);
    a8 = ta; b8 = tb2; op8 = top; flag_we8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    sb8.push_back(e);
    lat = 0;
    do begin @(negedge clk); lat++; end while (out_valid8 !== 1'b1 && lat < 50);
    e = sb8.pop_front();
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " result"}, result8, e.res[7:0]);
    chk({tag, " res_flags"}, res_flags8, e.rf);
    chk({tag, " alu_flags"}, alu_flags8, e.af);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_we = 1'b0;
    a = '0; b = '0; op = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; flag_we8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    model_af = 4'b0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset result", result, 0);
    chk("reset res_flags", res_flags, 0);
    chk("reset alu_flags", alu_flags, 0);

    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b1, "add ovf");
    collect("add ovf", 0);
    chk("add ovf const", {last_res, last_rf}, {32'h8000_0000, 4'b1001});
    issue(32'h0000_0005, 32'h0000_0005, 3'd1, 1'b1, "sub zero");
    collect("sub zero", 0);
    chk("sub zero const", {last_res, last_rf}, {32'h0, 4'b0110});
    issue(32'h0000_0000, 32'h0000_0001, 3'd1, 1'b1, "sub borrow");
    collect("sub borrow", 0);
    chk("sub borrow const", {last_res, last_rf}, {32'hFFFF_FFFF, 4'b1000});
    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b1, "add ovf2");
    collect("add ovf2", 0);
    issue(32'h0001_0003, 32'h0000_0005, 3'd5, 1'b1, "mul");
    collect("mul", 0);
    chk("mul const", {last_res, last_rf}, {32'h0005_000F, 4'b0001});
    issue(32'hF0F0_0000, 32'h0000_000F, 3'd3, 1'b0, "orr hold");
    collect("orr hold", 4);
    chk("orr const", {last_res, alu_flags}, {32'hF0F0_000F, 4'b0001});

    issue(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b1, "add carry");
    collect("add carry", 0);
    issue(32'h8000_0000, 32'h0000_0001, 3'd1, 1'b1, "sub ovf");
    collect("sub ovf", 0);
    issue(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd2, 1'b1, "and");
    collect("and", 0);
    issue(32'hAAAA_5555, 32'hFFFF_0000, 3'd4, 1'b1, "eor");
    collect("eor", 0);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 3'd6, 1'b1, "rsv6");
    collect("rsv6", 0);
    chk("rsv6 const", last_rf, 4'b0100);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 1'b1, "rsv7");
    collect("rsv7", 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b0, "mul wrap");
    collect("mul wrap", 0);

    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
      collect("rand", 0);
    end

    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 1'b1, "flags set");
    collect("flags set", 0);
    issue(32'h0000_1234, 32'h0000_0042, 3'd5, 1'b1, "mul reset");
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    model_af = 4'b0000;
    @(negedge clk);
    chk("rst mul out_valid", out_valid, 0);
    chk("rst mul in_ready", in_ready, 1);
    chk("rst mul alu_flags", alu_flags, 0);
    issue(32'h0000_0002, 32'h0000_0003, 3'd0, 1'b1, "add after rst");
    collect("add after rst", 0);
    chk("add after rst const", last_res, 32'h0000_0005);

    run8(8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001, 4'b1001, 1, "w8 add");
    run8(8'h0F, 8'h11, 3'd5, 8'hFF, 4'b1001, 4'b1001, 9, "w8 mul");
    run8(8'h05, 8'h05, 3'd1, 8'h00, 4'b0110, 4'b0110, 1, "w8 sub zero");
    run8(8'h00, 8'h01, 3'd1, 8'hFF, 4'b1000, 4'b1000, 1, "w8 sub borrow");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
